// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and default parameters for the gray_rx_decoder path.
// Both functions work on zero-extended vectors and stay correct for any width up to GRAY_MAX_W.
package gray_pkg;

  localparam int GRAY_MAX_W      = 32;
  localparam int DEF_N           = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_MAX_STEP    = 1;
  localparam int DEF_CNT_W       = 16;

  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/bus_sync.sv
// Plain multi-flop synchroniser for a bus that is already safe to sample bitwise (Gray coded).
// No logic between stages so that each stage has a full cycle to resolve metastability.
module bus_sync #(
  parameter int W      = 4,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         srst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage_reg [STAGES];

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_reg[i] <= '0;
      end
    end else begin
      stage_reg[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/gray_rx_decoder.sv
// Resynchronises a foreign-domain Gray count, decodes it to binary and reports the forward
// step per sample, flagging over-long (or backward) jumps and accumulating legal steps.
module gray_rx_decoder
  import gray_pkg::*;
#(
  parameter int N           = DEF_N,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int MAX_STEP    = DEF_MAX_STEP,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             srst_n,
  input  logic [N-1:0]     gray_in,
  input  logic             clr_err,
  output logic [N-1:0]     gray_sync,
  output logic [N-1:0]     bin_out,
  output logic [N-1:0]     step,
  output logic             step_valid,
  output logic             err_step,
  output logic             err_sticky,
  output logic [CNT_W-1:0] total_cnt,
  output logic             cnt_sat
);

  localparam int               SUM_W      = ((CNT_W > N) ? CNT_W : N) + 1;
  localparam logic [N-1:0]     MAX_STEP_N = N'(MAX_STEP);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic [N-1:0]     bin_new;
  logic [N-1:0]     diff;
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] total_next;

  logic [N-1:0]     bin_reg;
  logic [N-1:0]     step_reg;
  logic             step_valid_reg;
  logic             err_step_reg;
  logic             err_sticky_reg;
  logic [CNT_W-1:0] total_reg;

  bus_sync #(
    .W      (N),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .srst_n (srst_n),
    .d      (gray_in),
    .q      (gray_sync)
  );

  // Each binary bit is the XOR of all Gray bits at or above it; written flat to avoid a bit chain.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_decode
      assign bin_new[gi] = ^gray_sync[N-1:gi];
    end
  endgenerate

  // Modulo subtraction makes the top-to-zero wrap a step of 1 and a backward move a large step.
  assign diff = bin_new - bin_reg;

  always_comb begin
    sum        = SUM_W'(total_reg) + SUM_W'(step_reg);
    total_next = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      bin_reg        <= '0;
      step_reg       <= '0;
      step_valid_reg <= 1'b0;
      err_step_reg   <= 1'b0;
      err_sticky_reg <= 1'b0;
      total_reg      <= '0;
    end else begin
      bin_reg        <= bin_new;
      step_reg       <= diff;
      step_valid_reg <= (diff != '0);
      err_step_reg   <= (diff > MAX_STEP_N);
      if (step_valid_reg && !err_step_reg) begin
        total_reg <= total_next;
      end
      // A fresh error beats a simultaneous clear so no error can be lost.
      if (err_step_reg) begin
        err_sticky_reg <= 1'b1;
      end else if (clr_err) begin
        err_sticky_reg <= 1'b0;
      end
    end
  end

  assign bin_out    = bin_reg;
  assign step       = step_reg;
  assign step_valid = step_valid_reg;
  assign err_step   = err_step_reg;
  assign err_sticky = err_sticky_reg;
  assign total_cnt  = total_reg;
  assign cnt_sat    = (total_reg == CNT_MAX);

endmodule

// File: tb/tb_gray_rx_decoder.sv
// Self-checking bench for gray_rx_decoder: directed scenarios plus a random walk, checked against
// an arithmetic model of sample value, step, error flags and saturating accumulation.
module tb_gray_rx_decoder;
  import gray_pkg::*;

  localparam int N        = 4;
  localparam int MAX_STEP = 1;
  localparam int MODV     = 1 << N;
  localparam int MAX16    = 65535;
  localparam int MAX4     = 15;

  logic          clk = 1'b0;
  logic          srst_n = 1'b1;
  logic [N-1:0]  gray_in = '0;
  logic          clr_err = 1'b0;

  logic [N-1:0]  gray_sync, bin_out, step;
  logic          step_valid, err_step, err_sticky, cnt_sat;
  logic [15:0]   total_cnt;

  logic [N-1:0]  gray_sync4, bin_out4, step4;
  logic          step_valid4, err_step4, err_sticky4, cnt_sat4;
  logic [3:0]    total_cnt4;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt = 0;

  // Reference model state
  int m_prev   = 0;
  int m_total  = 0;
  int m_total4 = 0;
  bit m_sticky = 0;

  always #5 clk = ~clk;

  always @(negedge clk) if (step_valid === 1'b1) pulse_cnt++;

  gray_rx_decoder #(.N(N), .SYNC_STAGES(2), .MAX_STEP(MAX_STEP), .CNT_W(16)) dut (
    .clk(clk), .srst_n(srst_n), .gray_in(gray_in), .clr_err(clr_err),
    .gray_sync(gray_sync), .bin_out(bin_out), .step(step), .step_valid(step_valid),
    .err_step(err_step), .err_sticky(err_sticky), .total_cnt(total_cnt), .cnt_sat(cnt_sat)
  );

  gray_rx_decoder #(.N(N), .SYNC_STAGES(2), .MAX_STEP(MAX_STEP), .CNT_W(4)) dut4 (
    .clk(clk), .srst_n(srst_n), .gray_in(gray_in), .clr_err(clr_err),
    .gray_sync(gray_sync4), .bin_out(bin_out4), .step(step4), .step_valid(step_valid4),
    .err_step(err_step4), .err_sticky(err_sticky4), .total_cnt(total_cnt4), .cnt_sat(cnt_sat4)
  );

  function automatic logic [N-1:0] to_gray(input int v);
    logic [GRAY_MAX_W-1:0] g;
    g = bin2gray(GRAY_MAX_W'(v));
    return g[N-1:0];
  endfunction

  // Waits for a value already on gray_in to arrive, checks the sample, then the cycle after.
  task automatic check_sample(input int v, input bit clr);
    int d;
    d = (v - m_prev + MODV) % MODV;
    repeat (3) @(posedge clk);
    #1;
    $display("sample bin=%0d step=%0d valid=%0b err=%0b (exp step=%0d)", bin_out, step, step_valid, err_step, d);
    n_checks++; if (bin_out !== N'(v)) begin n_fail++; $display("FAIL bin_out: got %0d expected %0d", bin_out, v); end
    n_checks++; if (gray_sync !== to_gray(v)) begin n_fail++; $display("FAIL gray_sync: got %0h expected %0h", gray_sync, to_gray(v)); end
    n_checks++; if (step !== N'(d)) begin n_fail++; $display("FAIL step: got %0d expected %0d", step, d); end
    n_checks++; if (step_valid !== (d != 0)) begin n_fail++; $display("FAIL step_valid: got %0b expected %0b", step_valid, d != 0); end
    n_checks++; if (err_step !== (d > MAX_STEP)) begin n_fail++; $display("FAIL err_step: got %0b expected %0b", err_step, d > MAX_STEP); end
    if (d > MAX_STEP) m_sticky = 1;
    else if (clr) m_sticky = 0;
    if (d != 0 && d <= MAX_STEP) begin
      m_total  = (m_total + d > MAX16) ? MAX16 : m_total + d;
      m_total4 = (m_total4 + d > MAX4) ? MAX4 : m_total4 + d;
    end
    m_prev = v;
    if (clr) clr_err = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (step_valid !== 1'b0) begin n_fail++; $display("FAIL valid_pulse: got %0b expected 0", step_valid); end
    n_checks++; if (err_step !== 1'b0) begin n_fail++; $display("FAIL err_pulse: got %0b expected 0", err_step); end
    n_checks++; if (total_cnt !== 16'(m_total)) begin n_fail++; $display("FAIL total_cnt: got %0d expected %0d", total_cnt, m_total); end
    n_checks++; if (total_cnt4 !== 4'(m_total4)) begin n_fail++; $display("FAIL total_cnt4: got %0d expected %0d", total_cnt4, m_total4); end
    n_checks++; if (cnt_sat4 !== (m_total4 == MAX4)) begin n_fail++; $display("FAIL cnt_sat4: got %0b expected %0b", cnt_sat4, m_total4 == MAX4); end
    n_checks++; if (err_sticky !== m_sticky) begin n_fail++; $display("FAIL err_sticky: got %0b expected %0b", err_sticky, m_sticky); end
    if (clr) begin
      @(posedge clk);
      #1;
      m_sticky = 0;
      n_checks++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL err_sticky_clr: got %0b expected 0", err_sticky); end
      clr_err = 1'b0;
    end
  endtask

  task automatic apply(input int v, input bit clr);
    @(negedge clk);
    gray_in = to_gray(v);
    check_sample(v, clr);
  endtask

  task automatic do_reset(input int v);
    @(negedge clk);
    srst_n  = 1'b0;
    gray_in = to_gray(v);
    #2;
    n_checks++;
    if ({gray_sync, bin_out, step, step_valid, err_step, err_sticky, total_cnt, cnt_sat, total_cnt4} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got bin=%0d step=%0d total=%0d sticky=%0b expected all 0", bin_out, step, total_cnt, err_sticky);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    srst_n = 1'b1;
    m_prev = 0; m_total = 0; m_total4 = 0; m_sticky = 0;
    check_sample(v, 1'b0);
  endtask

  task automatic test_reset();
    $display("test_reset");
    do_reset(4);
  endtask

  task automatic test_sweep();
    $display("test_sweep");
    do_reset(0);
    pulse_cnt = 0;
    for (int v = 1; v <= 16; v++) apply(v % MODV, 1'b0);
    n_checks++; if (pulse_cnt != 16) begin n_fail++; $display("FAIL sweep_pulses: got %0d expected 16", pulse_cnt); end
    n_checks++; if (total_cnt !== 16'd16) begin n_fail++; $display("FAIL sweep_total: got %0d expected 16", total_cnt); end
    n_checks++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL sweep_sticky: got %0b expected 0", err_sticky); end
  endtask

  task automatic test_jump();
    $display("test_jump");
    for (int v = 1; v <= 5; v++) apply(v, 1'b0);
    apply(8, 1'b0);
    n_checks++; if (total_cnt !== 16'd21) begin n_fail++; $display("FAIL jump_total: got %0d expected 21", total_cnt); end
  endtask

  task automatic test_backward_clr();
    $display("test_backward_clr");
    apply(9, 1'b0);
    apply(8, 1'b1);
  endtask

  task automatic test_random();
    int v;
    int r;
    $display("test_random");
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6) v = (m_prev + 1) % MODV;
      else if (r < 7) v = m_prev;
      else v = int'($urandom_range(0, MODV - 1));
      apply(v, ($urandom_range(0, 3) == 0));
    end
  endtask

  task automatic test_saturate();
    $display("test_saturate");
    do_reset(0);
    for (int v = 1; v <= 20; v++) apply(v % MODV, 1'b0);
    n_checks++; if (total_cnt4 !== 4'd15) begin n_fail++; $display("FAIL sat_total4: got %0d expected 15", total_cnt4); end
    n_checks++; if (cnt_sat4 !== 1'b1) begin n_fail++; $display("FAIL sat_flag4: got %0b expected 1", cnt_sat4); end
    n_checks++; if (total_cnt !== 16'd20) begin n_fail++; $display("FAIL sat_total16: got %0d expected 20", total_cnt); end
    n_checks++; if (cnt_sat !== 1'b0) begin n_fail++; $display("FAIL sat_flag16: got %0b expected 0", cnt_sat); end
  endtask

  task automatic test_mid_reset();
    $display("test_mid_reset");
    apply(5, 1'b0);
    @(negedge clk);
    gray_in = to_gray(6);
    @(posedge clk);
    #2;
    srst_n = 1'b0;
    #1;
    n_checks++;
    if ({gray_sync, bin_out, step, step_valid, err_step, err_sticky, total_cnt, total_cnt4} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: got bin=%0d total=%0d gray=%0h expected all 0", bin_out, total_cnt, gray_sync);
    end
    @(negedge clk);
    srst_n = 1'b1;
    m_prev = 0; m_total = 0; m_total4 = 0; m_sticky = 0;
    check_sample(6, 1'b0);
    apply(7, 1'b0);
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_jump();
    test_backward_clr();
    test_random();
    test_saturate();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
